// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: divider state encoding, datapath width and
// the aluop codes that route DIV/DIVU to the divide sequencer.
package ex_pkg;

  localparam int EX_WIDTH = 32;

  // Divide sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_DIVZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  // aluop codes
  localparam logic [7:0] ALUOP_OR   = 8'b00100101;
  localparam logic [7:0] ALUOP_DIV  = 8'b00011010;
  localparam logic [7:0] ALUOP_DIVU = 8'b00011011;

  // True when an aluop needs the divide sequencer
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of radix-2 restoring division: shift the partial remainder
// left, bring in the next dividend bit, and keep the difference against the
// divisor only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] dvs_ext;

  // Trial subtract over WIDTH+1 bits; a remainder below the divisor always
  // fits back into WIDTH bits, whichever branch is taken.
  always_comb begin
    sh      = {rem_i, bit_i};
    dvs_ext = {1'b0, dvs_i};
    q_o     = (sh >= dvs_ext);
    rem_o   = q_o ? WIDTH'(sh - dvs_ext) : sh[WIDTH-1:0];
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer beside EX. Stalls the pipe while a divide
// runs and returns {remainder, quotient} for the HI/LO write path.
// Optional macro EX_DIV_EARLY_OUT_EN: finish immediately when |dividend| <
// |divisor| (quotient 0, remainder = dividend).
module ex_div_ctrl
  import ex_pkg::*;
#(
  parameter int WIDTH = EX_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   opv1,
  input  logic [WIDTH-1:0]   opv2,
  input  logic               cancel,
  output logic               stall_req,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend magnitude, quotient shifts in at LSB
  logic [WIDTH-1:0]     dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic                 neg1_q, neg1_d, neg2_q, neg2_d, sgn_q, sgn_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH-1:0]     step_rem, quo_next, q_fix, r_fix;
  logic                 step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand magnitudes and sign-corrected final result of the current step
  always_comb begin
    mag1     = (signed_op && opv1[WIDTH-1]) ? -opv1 : opv1;
    mag2     = (signed_op && opv2[WIDTH-1]) ? -opv2 : opv2;
    quo_next = {dvd_q[WIDTH-2:0], step_q};
    q_fix    = (sgn_q && (neg1_q ^ neg2_q)) ? -quo_next : quo_next;
    r_fix    = (sgn_q && neg1_q) ? -step_rem : step_rem;
  end

  // Next-state, datapath updates and stall request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    sgn_d     = sgn_q;
    result_d  = result_q;
    stall_req = start && !cancel && (state_q != DIV_END);

    case (state_q)
      DIV_IDLE: begin
        if (start && !cancel) begin
          if (opv2 == '0) begin
            state_d = DIV_DIVZERO;
          end else begin
`ifdef EX_DIV_EARLY_OUT_EN
            if (mag1 < mag2) begin
              state_d  = DIV_END;
              result_d = {opv1, {WIDTH{1'b0}}};
            end else begin
`endif
              state_d = DIV_ON;
              dvd_d   = mag1;
              dvs_d   = mag2;
              rem_d   = '0;
              neg1_d  = opv1[WIDTH-1];
              neg2_d  = opv2[WIDTH-1];
              sgn_d   = signed_op;
              cnt_d   = '0;
`ifdef EX_DIV_EARLY_OUT_EN
            end
`endif
          end
        end
      end
      DIV_DIVZERO: begin
        state_d  = DIV_END;
        result_d = '0;
      end
      DIV_ON: begin
        dvd_d = quo_next;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = DIV_END;
          result_d = {r_fix, q_fix};
        end
      end
      DIV_END: begin
        if (!start) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    // Flush wins over everything, including a start in the same cycle
    if (cancel) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end

    ready_d = (state_d == DIV_END);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sgn_q    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      sgn_q    <= sgn_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed cases plus random operands
// against an arithmetic reference model.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] opv1 = '0;
  logic [31:0] opv2 = '0;
  logic        cancel = 1'b0;
  logic        stall_req;
  logic        ready;
  logic [63:0] result;

  int nvec = 0;
  int nerr = 0;

  ex_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .opv1      (opv1),
    .opv2      (opv2),
    .cancel    (cancel),
    .stall_req (stall_req),
    .ready     (ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient}; zero divisor gives 0, signed truncates
  // toward zero with remainder taking the dividend's sign.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Expected ready cycle with acceptance cycle = 0
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    longint ma, mb;
    if (b == 0) return 2;
    ma = s ? longint'($signed(a)) : longint'({32'd0, a});
    mb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef EX_DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Issue one divide with start held until ready; leaves start high at
  // posedge+1 of the ready cycle. Reports latency (999 on timeout), result
  // and whether stall_req followed start/ready as expected.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit scramble, output int lat, output logic [63:0] res,
                         output bit stall_ok);
    @(negedge clk);
    opv1 = a; opv2 = b; signed_op = s; start = 1'b1;
    #1 stall_ok = (stall_req === 1'b1);
    lat = 0;
    res = '0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (ready === 1'b1) break;
      if (stall_req !== 1'b1) stall_ok = 0;
      if (scramble) begin
        opv1 = $urandom; opv2 = $urandom; signed_op = 1'($urandom_range(0, 1));
      end
    end
    if (ready === 1'b1) begin
      if (stall_req !== 1'b0) stall_ok = 0;
      res = result;
    end else begin
      lat = 999;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    nvec++;
    if (ready !== 1'b0 || result !== 64'd0 || stall_req !== 1'b0) begin
      nerr++;
      $display("FAIL reset: ready=%b result=%h stall=%b required 0/0/0", ready, result, stall_req);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int lat; logic [63:0] res; bit sok;
    run_div(32'd100, 32'd7, 1'b0, 1'b1, lat, res, sok);
    nvec++;
    if (lat !== 33) begin nerr++; $display("FAIL divu_lat: got %0d required 33", lat); end
    nvec++;
    if (res !== {32'd2, 32'd14}) begin nerr++; $display("FAIL divu_res: got %h required %h", res, {32'd2, 32'd14}); end
    nvec++;
    if (!sok) begin nerr++; $display("FAIL divu_stall: stall_req wrong during cycles 0..33"); end
    // start still held: remain in END with ready up and no stall
    @(posedge clk); #1;
    nvec++;
    if (ready !== 1'b1 || stall_req !== 1'b0 || result !== {32'd2, 32'd14}) begin
      nerr++; $display("FAIL divu_hold: ready=%b stall=%b result=%h required 1/0/%h", ready, stall_req, result, {32'd2, 32'd14});
    end
    start = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (ready !== 1'b0) begin nerr++; $display("FAIL divu_drop: ready=%b required 0", ready); end
  endtask

  task automatic test_signed;
    int lat; logic [63:0] res; bit sok;
    run_div(-32'sd7, 32'd2, 1'b1, 1'b0, lat, res, sok);
    nvec++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33) begin
      nerr++; $display("FAIL div_neg7_2: got %h lat %0d required %h lat 33", res, lat, {32'hFFFFFFFF, 32'hFFFFFFFD});
    end
    start = 1'b0; @(posedge clk); #1;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, lat, res, sok);
    nvec++;
    if (res !== {32'd0, 32'h80000000} || lat !== 33) begin
      nerr++; $display("FAIL div_ovf: got %h lat %0d required %h lat 33", res, lat, {32'd0, 32'h80000000});
    end
    start = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_divzero;
    int lat; logic [63:0] res; bit sok;
    run_div(32'd12345, 32'd0, 1'b0, 1'b0, lat, res, sok);
    nvec++;
    if (lat !== 2 || res !== 64'd0 || !sok) begin
      nerr++; $display("FAIL divzero: lat %0d result %h stall_ok %0d required lat 2 result 0 stall_ok 1", lat, res, sok);
    end
    start = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_cancel;
    int lat; logic [63:0] prev, res; bit sok; bit saw_ready;
    prev = result;
    @(negedge clk);
    opv1 = 32'd100; opv2 = 32'd7; signed_op = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    #1;
    nvec++;
    if (stall_req !== 1'b0) begin nerr++; $display("FAIL cancel_stall: stall=%b required 0", stall_req); end
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    saw_ready = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) saw_ready = 1;
    end
    nvec++;
    if (saw_ready || result !== prev) begin
      nerr++; $display("FAIL cancel_hold: saw_ready=%0d result=%h required 0/%h", saw_ready, result, prev);
    end
    // Sequencer must be back in IDLE: a fresh divide takes the full latency
    run_div(32'd100, 32'd7, 1'b0, 1'b0, lat, res, sok);
    nvec++;
    if (lat !== 33 || res !== {32'd2, 32'd14}) begin
      nerr++; $display("FAIL cancel_restart: lat %0d result %h required 33/%h", lat, res, {32'd2, 32'd14});
    end
    start = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [63:0] res; bit sok;
    @(negedge clk);
    opv1 = 32'd1234; opv2 = 32'd5; signed_op = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1; start = 1'b0;
    #1;
    nvec++;
    if (ready !== 1'b0 || result !== 64'd0 || stall_req !== 1'b0) begin
      nerr++; $display("FAIL reset_mid: ready=%b result=%h stall=%b required 0/0/0", ready, result, stall_req);
    end
    @(negedge clk); rst = 1'b0;
    run_div(32'd1000, 32'd3, 1'b0, 1'b0, lat, res, sok);
    nvec++;
    if (lat !== 33 || res !== {32'd1, 32'd333}) begin
      nerr++; $display("FAIL reset_restart: lat %0d result %h required 33/%h", lat, res, {32'd1, 32'd333});
    end
    start = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_early_out;
    int lat; logic [63:0] res; bit sok; int elat;
    elat = exp_lat(32'd3, 32'd10, 1'b0);
    run_div(32'd3, 32'd10, 1'b0, 1'b0, lat, res, sok);
    nvec++;
    if (lat !== elat || res !== {32'd3, 32'd0}) begin
      nerr++; $display("FAIL early_out: lat %0d result %h required %0d/%h", lat, res, elat, {32'd3, 32'd0});
    end
    start = 1'b0; @(posedge clk); #1;
    elat = exp_lat(-32'sd3, 32'd10, 1'b1);
    run_div(-32'sd3, 32'd10, 1'b1, 1'b0, lat, res, sok);
    nvec++;
    if (lat !== elat || res !== {32'hFFFFFFFD, 32'd0}) begin
      nerr++; $display("FAIL early_out_signed: lat %0d result %h required %0d/%h", lat, res, elat, {32'hFFFFFFFD, 32'd0});
    end
    start = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat; logic [63:0] res; bit sok;
    logic [31:0] a, b; logic s; int sel;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel < 3)  b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = a ^ 32'h40000000;
      else               b = $urandom >> $urandom_range(0, 31);
      if (b == 0 && sel != 0) b = 32'd1;
      s = 1'($urandom_range(0, 1));
      run_div(a, b, s, 1'b1, lat, res, sok);
      nvec++;
      if (lat !== exp_lat(a, b, s) || res !== model(a, b, s) || !sok) begin
        nerr++;
        $display("FAIL rand%0d: a=%h b=%h s=%b lat %0d result %h stall_ok %0d required lat %0d result %h",
                 i, a, b, s, lat, res, sok, exp_lat(a, b, s), model(a, b, s));
      end
      start = 1'b0;
      @(posedge clk); #1;
      nvec++;
      if (ready !== 1'b0) begin nerr++; $display("FAIL rand%0d_drop: ready=%b required 0", i, ready); end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_divzero;
    test_cancel;
    test_reset_mid;
    test_early_out;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
- Multi-cycle divide sequencer beside the EX stage; the EX ALU has no divider.
- Accepts DIV/DIVU operands from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline through stall_req until the result is ready.
- Returns {remainder, quotient} for the HI/LO write path. Pipeline flush cancels it.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX requests a divide. Held high by EX until it sees ready.
- signed_op  in  1  1 = DIV (two's complement), 0 = DIVU
- opv1  in  WIDTH  dividend, sampled only on acceptance
- opv2  in  WIDTH  divisor, sampled only on acceptance
- cancel  in  1  flush. Aborts any operation in progress.
- stall_req  out  1  stall request to pipeline control
- ready  out  1  result valid
- result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, ready=0, result=0, internal operand/remainder registers=0.
- States: IDLE, DIVZERO, ON, END. Encoding constants live in the package.
- stall_req is combinational: start & ~cancel & (state != END).
  - It rises in the same cycle EX raises start.
  - It drops in the END cycle, so EX retires the instruction that cycle.
- IDLE:
  - start & ~cancel & opv2==0 -> DIVZERO.
  - start & ~cancel & opv2!=0 -> ON. Latch |opv1| and |opv2| (magnitudes only when signed_op=1), the two operand signs, and signed_op; counter=0.
- ON:
  - Each cycle: shift partial remainder left 1, bring in the next dividend bit, subtract divisor (WIDTH+1-bit subtract).
  - Non-negative difference: keep it, quotient bit=1. Negative: restore, quotient bit=0.
  - counter increments each cycle. After the step with counter==WIDTH-1 -> END.
  - Result register written on that transition with sign correction:
    - quotient negated if signed_op and the operand signs differ;
    - remainder negated if signed_op and the dividend was negative.
- DIVZERO: one cycle, then -> END with result=0. No exception is raised.
- END:
  - ready=1 (registered, asserted while in END).
  - Stay in END while start=1. start=0 -> IDLE, ready=0 next cycle.
  - result holds its value until the next result write or reset.
- Latency, with acceptance edge = cycle 0: normal divide ready in cycle WIDTH+1 (33). Divide-by-zero ready in cycle 2.
- cancel:
  - In any state -> IDLE next edge, ready=0, result not updated.
  - cancel beats start in the same cycle.
- Operand changes on opv1/opv2/signed_op while in ON or END are ignored.
- Signed overflow (0x80000000 / 0xFFFFFFFF) wraps: quotient=0x80000000, remainder=0.
- Back-to-back operations: start must go low for at least one cycle (END->IDLE) before the next acceptance.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined: in IDLE with start & ~cancel, opv2!=0 and |opv1| < |opv2| -> END directly, with quotient=0 and remainder=opv1 (unchanged, sign preserved). Ready in cycle 1.
- Undefined: all nonzero-divisor operations take the full WIDTH iterations. Same results, longer latency.

Decomposition:
- Shared package ex_pkg:
  - div state encoding (DIV_IDLE, DIV_DIVZERO, DIV_ON, DIV_END);
  - WIDTH default;
  - aluop codes for DIV/DIVU, next to the existing OR aluop 8'b00100101.
- Natural sub-module: div_step, the combinational one-iteration restoring step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit.
- FSM, counter and sign correction stay in ex_div_ctrl.

Test Plan:
- Unsigned: DIVU 100/7, start held -> stall_req=1 cycles 0..32, ready in cycle 33, result={32'd2, 32'd14}. start low -> ready=0 next cycle.
- Signed: DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
- Divide by zero: opv2=0 -> ready in cycle 2, result=0, no ON state visited.
- Cancel mid-operation: cancel at cycle 10 of 100/7 -> IDLE next edge, ready stays 0, result keeps its previous value.
- Reset mid-operation: rst at cycle 5 -> all outputs 0 immediately, without waiting for a clock edge. A new divide after reset completes correctly.
- With EX_DIV_EARLY_OUT_EN: DIVU 3/10 -> ready in cycle 1, result={32'd3, 32'd0}. Without the macro, the same operation is ready in cycle 33.
